decl_arbiter: RTL and testbench

DECL_ARBITER -- requirements
Module: decl_arbiter

---
 rtl/decl_arbiter.sv | 113 +++++++++++
 tb/tb_decl_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decl_arbiter.sv
// Round-robin arbiter sharing one declaration checker between two character streams.
// Each grant covers a whole statement, which ends at ';' or at MAX_LEN characters.
module decl_arbiter #(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       chk_en,
  output logic [7:0] chk_data,
  output logic       chk_clr,
  input  logic       chk_out,
  output logic       res0_valid,
  output logic       res1_valid,
  output logic       res_ok,
  output logic       owner,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic [8:0] max_len_c = 9'(MAX_LEN);

  state_t     state_r;
  logic       owner_r;
  logic       last_r;
  logic       verdict_r;
  logic [7:0] cnt_r;

  logic       own_valid_s;
  logic [7:0] own_data_s;
  logic       xfer_s;
  logic       semi_s;
  logic [8:0] cnt_inc_s;
  logic       cnt_hit_s;

  // Owner-side handshake decode and character-budget check.
  always_comb begin
    own_valid_s = owner_r ? req1_valid : req0_valid;
    own_data_s  = owner_r ? req1_data : req0_data;
    xfer_s      = (state_r == STREAM) && own_valid_s;
    semi_s      = (own_data_s == 8'h3B);
    cnt_inc_s   = {1'b0, cnt_r} + 9'd1;
    cnt_hit_s   = (cnt_inc_s >= max_len_c);
  end

  // Statement FSM: grant, stream, let the checker settle, report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      verdict_r <= 1'b0;
      cnt_r     <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            // With both waiting, the requester not served last wins.
            owner_r <= (req0_valid && req1_valid) ? ~last_r : req1_valid;
            cnt_r   <= 8'd0;
            state_r <= STREAM;
          end
        end
        STREAM: begin
          if (xfer_s) begin
            cnt_r <= cnt_inc_s[7:0];
            if (semi_s) begin
              state_r <= WAIT;
            end else if (cnt_hit_s) begin
              verdict_r <= 1'b0;
              state_r   <= RESULT;
            end
          end
        end
        WAIT: begin
          verdict_r <= chk_out;
          state_r   <= RESULT;
        end
        RESULT: begin
          last_r  <= owner_r;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state; only the transfer follows live inputs.
  assign req0_ready = (state_r == STREAM) && !owner_r;
  assign req1_ready = (state_r == STREAM) && owner_r;
  assign chk_en     = xfer_s;
  assign chk_data   = xfer_s ? own_data_s : 8'h00;
  assign chk_clr    = (state_r == RESULT);
  assign res0_valid = (state_r == RESULT) && !owner_r;
  assign res1_valid = (state_r == RESULT) && owner_r;
  assign res_ok     = (state_r == RESULT) && verdict_r;
  assign owner      = owner_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_decl_arbiter.sv
// Bench for decl_arbiter: a small declaration-checker stub closes the loop, and a
// statement-level round-robin model predicts grant order, verdicts and timing.
module tb_decl_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, chk_en, chk_clr, chk_out;
  logic [7:0] chk_data;
  logic       res0_valid, res1_valid, res_ok, owner, busy;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit    own;
    string s;
    bit    ok;
    bit    tmo;
  } exp_t;

  logic [7:0] q0[$], q1[$];
  exp_t       expq[$];
  string      sa[$], sb[$];

  always #5 clk = ~clk;

  decl_arbiter #(.MAX_LEN(255)) dut (
    .clk(clk), .reset(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .chk_en(chk_en), .chk_data(chk_data), .chk_clr(chk_clr), .chk_out(chk_out),
    .res0_valid(res0_valid), .res1_valid(res1_valid), .res_ok(res_ok),
    .owner(owner), .busy(busy)
  );

  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_";
  endfunction

  function automatic bit is_digit(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  // Checker stub: recognises "int <ident>;" one character at a time.
  logic [2:0] cs_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_r <= 3'd0;
    else if (chk_clr) cs_r <= 3'd0;
    else if (chk_en) begin
      case (cs_r)
        3'd0: cs_r <= (chk_data == "i") ? 3'd1 : 3'd7;
        3'd1: cs_r <= (chk_data == "n") ? 3'd2 : 3'd7;
        3'd2: cs_r <= (chk_data == "t") ? 3'd3 : 3'd7;
        3'd3: cs_r <= (chk_data == " ") ? 3'd4 : 3'd7;
        3'd4: cs_r <= is_alpha(chk_data) ? 3'd5 : 3'd7;
        3'd5: cs_r <= (chk_data == ";") ? 3'd6 :
                      (is_alpha(chk_data) || is_digit(chk_data)) ? 3'd5 : 3'd7;
        default: cs_r <= 3'd7;
      endcase
    end
  end
  assign chk_out = (cs_r == 3'd6);

  // Whole-string reference verdict.
  function automatic bit is_decl(input string s);
    if (s.len() < 6) return 1'b0;
    if (s.substr(0, 3) != "int ") return 1'b0;
    if (s[s.len()-1] != ";") return 1'b0;
    if (is_digit(s[4])) return 1'b0;
    for (int i = 4; i < s.len() - 1; i++)
      if (!(is_alpha(s[i]) || is_digit(s[i]))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string rand_stmt();
    string alnum = "abcxyz0189_";
    string id;
    int k = $urandom_range(0, 4);
    id = $sformatf("%c", 8'(97 + $urandom_range(0, 25)));
    repeat ($urandom_range(0, 4)) id = $sformatf("%s%c", id, alnum[$urandom_range(0, 10)]);
    case (k)
      0, 1: return {"int ", id, ";"};
      2: return {"int 7", id, ";"};
      3: return {"itn ", id, ";"};
      default: return "int;";
    endcase
  endfunction

  task automatic push_stmt(input bit who, input string s);
    for (int i = 0; i < s.len(); i++)
      if (who) q1.push_back(s[i]); else q0.push_back(s[i]);
  endtask

  // Round-robin at statement level, both requesters always offering while they have work.
  task automatic plan();
    int i = 0, j = 0;
    bit last = 1'b1, pick;
    while (i < sa.size() || j < sb.size()) begin
      if (i < sa.size() && j < sb.size()) pick = !last;
      else pick = (j < sb.size());
      if (!pick) begin
        push_stmt(1'b0, sa[i]); expq.push_back('{1'b0, sa[i], is_decl(sa[i]), 1'b0}); i++;
      end else begin
        push_stmt(1'b1, sb[j]); expq.push_back('{1'b1, sb[j], is_decl(sb[j]), 1'b0}); j++;
      end
      last = pick;
    end
    sa.delete(); sb.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, owner, req0_ready, req1_ready, chk_en, chk_clr, res0_valid, res1_valid,
         res_ok, chk_data} !== 17'd0)
      begin n_fail++; $display("FAIL reset_outputs: got busy=%b owner=%b rdy=%b%b en=%b clr=%b res=%b%b ok=%b data=%h want all 0",
        busy, owner, req0_ready, req1_ready, chk_en, chk_clr, res0_valid, res1_valid, res_ok, chk_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives both queues cycle by cycle and checks every observed event against the plan.
  task automatic run(input int max_cyc, input int gap_at);
    int cyc = 0, last_x = -100, sent0 = 0, gap0 = 0;
    string cur = "";
    bit prev_res = 1'b0, xfer0, xfer1;
    logic [7:0] exp_d;
    exp_t e;
    while (cyc < max_cyc) begin
      @(negedge clk);
      req0_valid = (q0.size() > 0) && (gap0 == 0);
      req0_data  = req0_valid ? q0[0] : 8'($urandom);
      req1_valid = (q1.size() > 0);
      req1_data  = req1_valid ? q1[0] : 8'($urandom);
      if (gap0 > 0) gap0--;
      #1;
      xfer0 = req0_valid && req0_ready;
      xfer1 = req1_valid && req1_ready;
      n_cmp++;
      if (chk_en !== (xfer0 || xfer1))
        begin n_fail++; $display("FAIL chk_en cyc %0d: got %b want %b", cyc, chk_en, xfer0 || xfer1); end
      n_cmp++;
      if ((req0_ready && owner !== 1'b0) || (req1_ready && owner !== 1'b1))
        begin n_fail++; $display("FAIL foreign_ready cyc %0d: got rdy0=%b rdy1=%b owner=%b want only owner ready", cyc, req0_ready, req1_ready, owner); end
      if (prev_res) begin
        n_cmp++;
        if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
          begin n_fail++; $display("FAIL post_result_idle cyc %0d: got busy=%b rdy=%b%b want 0", cyc, busy, req0_ready, req1_ready); end
      end
      if (xfer0 || xfer1) begin
        exp_d = xfer0 ? req0_data : req1_data;
        n_cmp++;
        if (chk_data !== exp_d)
          begin n_fail++; $display("FAIL chk_data cyc %0d: got %h want %h", cyc, chk_data, exp_d); end
        cur = $sformatf("%s%c", cur, exp_d);
        last_x = cyc;
        if (xfer0) begin
          void'(q0.pop_front());
          sent0++;
          if (sent0 == gap_at) gap0 = 3;
        end else void'(q1.pop_front());
      end
      if (res0_valid || res1_valid) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL unexpected_result cyc %0d: got res=%b%b want none", cyc, res0_valid, res1_valid);
        end else begin
          e = expq.pop_front();
          if (res1_valid !== e.own || res0_valid === res1_valid)
            begin n_fail++; $display("FAIL res_owner cyc %0d: got res0=%b res1=%b want owner %0d", cyc, res0_valid, res1_valid, e.own); end
          n_cmp++;
          if (res_ok !== e.ok)
            begin n_fail++; $display("FAIL res_ok cyc %0d: got %b want %b", cyc, res_ok, e.ok); end
          n_cmp++;
          if (chk_clr !== 1'b1)
            begin n_fail++; $display("FAIL chk_clr cyc %0d: got %b want 1", cyc, chk_clr); end
          n_cmp++;
          if (cur != e.s) begin
            n_fail++;
            if (cur.len() <= 64 && e.s.len() <= 64) $display("FAIL stmt_chars: got \"%s\" want \"%s\"", cur, e.s);
            else $display("FAIL stmt_chars: got %0d chars want %0d chars", cur.len(), e.s.len());
          end
          n_cmp++;
          if (cyc != last_x + (e.tmo ? 1 : 2))
            begin n_fail++; $display("FAIL result_latency: got cycle %0d want %0d", cyc, last_x + (e.tmo ? 1 : 2)); end
        end
        cur = "";
        prev_res = 1'b1;
      end else begin
        n_cmp++;
        if (res_ok !== 1'b0 || chk_clr !== 1'b0)
          begin n_fail++; $display("FAIL idle_pulses cyc %0d: got res_ok=%b chk_clr=%b want 0", cyc, res_ok, chk_clr); end
        prev_res = 1'b0;
      end
      if (q0.size() == 0 && q1.size() == 0 && expq.size() == 0 && !busy) break;
      cyc++;
    end
    if (cyc >= max_cyc) begin
      n_cmp++; n_fail++;
      $display("FAIL run_timeout: got %0d pending results after %0d cycles want 0", expq.size(), max_cyc);
      q0.delete(); q1.delete(); expq.delete();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    sa.push_back("int a;");
    plan();
    run(200, 0);
  endtask

  task automatic test_both_valid();
    apply_reset();
    sa.push_back("int x;");
    sb.push_back("int 7;");
    plan();
    run(200, 0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    sa.push_back("int a1;"); sa.push_back("int 9;"); sa.push_back("int _q;");
    sb.push_back("int b;");  sb.push_back("itn c;"); sb.push_back("int zz9;");
    plan();
    run(400, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      repeat ($urandom_range(1, 5)) sa.push_back(rand_stmt());
      repeat ($urandom_range(0, 5)) sb.push_back(rand_stmt());
      plan();
      run(1000, 0);
    end
  endtask

  task automatic test_timeout();
    string s = "";
    apply_reset();
    repeat (255) s = {s, "a"};
    push_stmt(1'b0, s);
    expq.push_back('{1'b0, s, 1'b0, 1'b1});
    push_stmt(1'b0, "a;");
    expq.push_back('{1'b0, "a;", 1'b0, 1'b0});
    run(1000, 0);
  endtask

  task automatic test_valid_gap();
    apply_reset();
    sa.push_back("int abc;");
    plan();
    run(200, 2);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk); req0_valid = 1'b1; req0_data = "i";
    @(negedge clk);
    @(negedge clk); req0_data = "n";
    @(negedge clk); req0_data = "t";
    n_cmp++;
    if (busy !== 1'b1)
      begin n_fail++; $display("FAIL mid_stmt_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, owner, req0_ready, req1_ready, chk_en, chk_clr, res0_valid, res1_valid,
         res_ok, chk_data} !== 17'd0)
      begin n_fail++; $display("FAIL async_reset_outputs: got busy=%b rdy=%b en=%b res=%b%b data=%h want all 0",
        busy, req0_ready, chk_en, res0_valid, res1_valid, chk_data); end
    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0;
    sa.push_back("int q;");
    plan();
    run(200, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_valid();
    test_back_to_back();
    test_random();
    test_timeout();
    test_valid_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
